// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative 32-cycle multiply/divide unit with HI/LO registers
// Shift-add multiply and restoring divide share one 2*WIDTH accumulator; sign fix-up happens in FIX.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state, state_next;
  logic [CW-1:0]      cnt;
  logic               is_div, div_zero, neg_res, neg_rem;
  logic [WIDTH-1:0]   a_raw, b_mag;
  logic [2*WIDTH-1:0] acc, acc_step, prod_fix;
  logic [WIDTH:0]     add_sum, sub_trial;
  logic [WIDTH-1:0]   a_mag_in, b_mag_in, quo_fix, rem_fix;
  logic               sgn_op;

  assign sgn_op   = ~op[0];
  assign a_mag_in = (sgn_op && rs_data[WIDTH-1]) ? -rs_data : rs_data;
  assign b_mag_in = (sgn_op && rt_data[WIDTH-1]) ? -rt_data : rt_data;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt == CW'(WIDTH-1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN) || (state == FIX);
    done = (state == FIX);
  end

  // Multiply: add B into the high half when the low bit is set, then shift right.
  // Divide: shift remainder:dividend left and keep the trial subtraction if it does not borrow.
  always_comb begin
    add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, b_mag};
    sub_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, b_mag};
    acc_step  = acc;
    if (is_div) begin
      if (!sub_trial[WIDTH]) acc_step = {sub_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else                   acc_step = {acc[2*WIDTH-2:0], 1'b0};
    end else if (acc[0]) begin
      acc_step = {add_sum, acc[WIDTH-1:1]};
    end else begin
      acc_step = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

  always_comb begin
    prod_fix = neg_res ? -acc : acc;
    quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      a_raw    <= '0;
      b_mag    <= '0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt      <= '0;
            acc      <= {{WIDTH{1'b0}}, a_mag_in};
            is_div   <= op[1];
            div_zero <= (rt_data == '0);
            neg_res  <= sgn_op && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
            neg_rem  <= sgn_op && rs_data[WIDTH-1];
            a_raw    <= rs_data;
            b_mag    <= b_mag_in;
          end else begin
            if (hi_we) hi <= rs_data;
            if (lo_we) lo <= rs_data;
          end
        end
        RUN: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          if (is_div && div_zero) begin
            hi <= a_raw;
            lo <= '1;
          end else if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data, rt_data;
  logic        hi_we, lo_we;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .hi_we(hi_we), .lo_we(lo_we),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) until busy drops, counting busy cycles and done pulses at negedges.
  task automatic wait_idle(output int bcyc, output int dcnt);
    bcyc = 0;
    dcnt = 0;
    while (busy && bcyc < 100) begin
      if (done) dcnt++;
      bcyc++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int bcyc, output int dcnt);
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(negedge clk);
    start = 1'b0; op = 2'b00; rs_data = 32'h5555_AAAA; rt_data = 32'h0F0F_0F0F;
    wait_idle(bcyc, dcnt);
  endtask

  typedef struct {
    string       tag;
    logic [1:0]  o;
    logic [31:0] a, b, exp_hi, exp_lo;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int bc, dc;
    logic [31:0] hi_before;

    rst_n = 1'b0; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
    hi_we = 1'b0; lo_we = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    rst_n = 1'b1;

    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, dc);
    check("multu_max_busy_cycles", bc, 33);
    check("multu_max_done_pulses", dc, 1);
    check("multu_max_hi", hi, 32'hFFFF_FFFE);
    check("multu_max_lo", lo, 32'h0000_0001);

    vecs.push_back('{"mult_neg3x7",    MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB});
    vecs.push_back('{"mult_min_sq",    MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000});
    vecs.push_back('{"divu_100_7",     DIVU,  32'd100,       32'd7,        32'd2,         32'd14});
    vecs.push_back('{"div_m7_2",       DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{"div_7_m2",       DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD});
    vecs.push_back('{"divu_by_zero",   DIVU,  32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF});
    vecs.push_back('{"div_by_zero",    DIV,   32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF});
    vecs.push_back('{"div_overflow",   DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
    vecs.push_back('{"multu_3x4",      MULTU, 32'd3,         32'd4,        32'd0,         32'd12});

    foreach (vecs[i]) begin
      run_op(vecs[i].o, vecs[i].a, vecs[i].b, bc, dc);
      check({vecs[i].tag, "_cycles"}, bc, 33);
      check({vecs[i].tag, "_hi"}, hi, vecs[i].exp_hi);
      check({vecs[i].tag, "_lo"}, lo, vecs[i].exp_lo);
    end

    // start and hi_we mid-operation must be ignored
    hi_before = hi;
    @(negedge clk);
    start = 1'b1; op = DIVU; rs_data = 32'd100; rt_data = 32'd7;
    @(negedge clk);
    start = 1'b0; rs_data = 32'h0; rt_data = 32'h0;
    repeat (4) @(negedge clk);
    start = 1'b1; hi_we = 1'b1; op = MULTU; rs_data = 32'hAAAA_0000; rt_data = 32'd3;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    check("hazard_hi_unchanged", hi, hi_before);
    check("hazard_busy", {31'd0, busy}, 32'd1);
    wait_idle(bc, dc);
    check("hazard_done_pulses", dc, 1);
    check("hazard_hi", hi, 32'd2);
    check("hazard_lo", lo, 32'd14);
    repeat (3) @(negedge clk);
    check("hazard_no_queued_op", {31'd0, busy}, 32'd0);
    check("hold_hi", hi, 32'd2);

    // reset in the middle of a DIVU
    @(negedge clk);
    start = 1'b1; op = DIVU; rs_data = 32'd1000; rt_data = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);

    run_op(MULTU, 32'd3, 32'd4, bc, dc);
    check("postrst_cycles", bc, 33);
    check("postrst_hi", hi, 32'd0);
    check("postrst_lo", lo, 32'd12);

    // idle move-to writes
    @(negedge clk);
    rs_data = 32'hDEAD_BEEF; lo_we = 1'b1;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo_lo", lo, 32'hDEAD_BEEF);
    check("mtlo_hi", hi, 32'd0);
    rs_data = 32'hCAFE_F00D; hi_we = 1'b1;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi_hi", hi, 32'hCAFE_F00D);
    check("mthi_lo", lo, 32'hDEAD_BEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the single-cycle CPU, sitting directly downstream of the register file read ports. It takes the two source operands read from the register file, computes a 64-bit product, or a quotient and remainder, over 33 cycles, and holds the result in architectural HI/LO registers. The HI/LO outputs feed the register file write-data mux for move-from-HI and move-from-LO writeback. The control unit stalls the PC while `busy` is high.

## Interface

Parameters:
- `WIDTH`, 32, operand width; the counter width is derived from it.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous, active-low reset
- `start`  in  1  request a new operation; sampled only when idle
- `op`  in  2  operation select: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- `rs_data`  in  WIDTH  operand A / dividend, taken from register file read_data1
- `rt_data`  in  WIDTH  operand B / divisor, taken from register file read_data2
- `hi_we`  in  1  move-to-HI write enable
- `lo_we`  in  1  move-to-LO write enable
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle pulse: HI/LO just updated by a completed operation
- `hi`  out  WIDTH  HI register (product high word / remainder)
- `lo`  out  WIDTH  LO register (product low word / quotient)

## Operation

- States: IDLE, RUN, FIX.
- IDLE:
  - `start`=1 → latch `op`, the operand magnitudes and the result signs; clear counter; go to RUN.
  - Operands are converted to absolute values only for signed ops.
- RUN: one iteration per cycle for WIDTH cycles, then go to FIX.
  - Multiply: shift-add over a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract, quotient bit per cycle.
- FIX:
  - Apply sign correction.
  - Write HI/LO; `done`=1 for this cycle only; return to IDLE.
- Signed multiply: negate the 64-bit product if the operand signs differ.
- Signed divide:
  - Quotient is truncated toward zero; negate it if the signs differ.
  - Remainder takes the sign of the dividend.
- Divide by zero, signed or unsigned: lo=0xFFFFFFFF, hi=rs_data. No trap.
- Signed overflow (0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0.
- `hi_we` / `lo_we`: write `rs_data` into HI / LO at the clock edge. They take effect only in IDLE with `start`=0; otherwise they are ignored.
- `start` while RUN/FIX: ignored; no queuing.
- `op`, `rs_data` and `rt_data` may change freely after acceptance; the latched copies are used.

## Timing

- Reset (`rst_n`=0 at a rising edge), including in the middle of an operation:
  - State goes to IDLE; the operation is abandoned.
  - Outputs: busy=0, done=0, hi=0, lo=0, counter=0.
- `start` is accepted at edge E0.
- `busy`:
  - Goes high after E0.
  - Stays high through RUN (edges E1..E32) and FIX.
  - Falls after edge E33, the FIX→IDLE edge.
- `busy` is a registered state decode (RUN or FIX); no combinational path from `start`.
- HI/LO change only at edge E33 and `done` is high for the cycle ending at E33. The control unit may therefore capture HI/LO from the cycle after E33.
- Latency: 33 cycles from the accepting edge to the HI/LO update.
- Throughput: back-to-back `start` is accepted at E33+1 at the earliest. There is no acceptance at E33 itself, because the state is still FIX there.
- HI/LO hold their value across IDLE indefinitely.

## Test plan

- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. `busy` high for exactly 33 cycles; `done` pulses once.
- MULT −3 (0xFFFFFFFD) × 7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000 × 0x80000000 → hi=0x40000000, lo=0.
- DIVU 100 / 7 → lo=14, hi=2. DIV −7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 7 / −2 → lo=0xFFFFFFFD, hi=1.
- Edge cases:
  - DIVU 0x1234 / 0 → lo=0xFFFFFFFF, hi=0x1234.
  - DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Busy-time hazards:
  - Pulse `start` and `hi_we` with new operands 5 cycles into an operation → ignored. Result matches the original operands; HI is unchanged by `hi_we`.
- Reset and move-to writes:
  - Drive `rst_n`=0 for one edge 10 cycles into a DIVU → busy=0, done=0, hi=lo=0 next cycle. A following MULTU 3×4 → lo=12, hi=0.
  - Idle `lo_we` with rs_data=0xDEADBEEF → lo=0xDEADBEEF next cycle; hi unchanged.
